// File: rtl/mem_arbiter.sv
// Shares one single-ported word memory between instruction fetch and load/store.
// Handles arbitration with anti-starvation, store lane steering, load extension and misalignment.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_misalign,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       uns;
        logic       we;
        logic       mis;
    } rsp_ctx_t;

    owner_e           owner_q, owner_d;
    rsp_ctx_t         ctx_q, ctx_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic        fetch_force;
    logic        d_mis;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Byte-address bits the word-organised memory never sees
    logic unused_bits;
    assign unused_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0], d_addr[31:ADDR_WIDTH+2]};

    assign fetch_force = (starve_q == CNT_W'(STARVE_LIMIT));
    assign d_mis       = ((d_size == 2'b01) && d_addr[0]) || (d_size[1] && (d_addr[1:0] != 2'b00));

    // Store lane steering: replicate data across lanes, enable only the addressed bytes
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = d_wdata;
        case (d_size)
            2'b00: begin
                store_be    = 4'b0001 << d_addr[1:0];
                store_wdata = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                store_be    = d_addr[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = d_wdata;
            end
        endcase
    end

    // State register: response owner, its captured context, and fetch starvation count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            ctx_q    <= '0;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            ctx_q    <= ctx_d;
            starve_q <= starve_d;
        end
    end

    // Next state: record who owns next cycle's response
    always_comb begin
        owner_d  = OWN_NONE;
        ctx_d    = ctx_q;
        starve_d = starve_q;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt) begin
            owner_d    = OWN_D;
            ctx_d.off  = d_addr[1:0];
            ctx_d.size = d_size;
            ctx_d.uns  = d_unsigned;
            ctx_d.we   = d_we;
            ctx_d.mis  = d_mis;
        end
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Outputs: arbitration and memory drive for this cycle; nothing is granted while in reset
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (if_req && (fetch_force || !d_req)) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr[ADDR_WIDTH+1:2];
            end else if (d_req) begin
                d_gnt = 1'b1;
                if (!d_mis) begin
                    mem_en   = 1'b1;
                    mem_we   = d_we;
                    mem_addr = d_addr[ADDR_WIDTH+1:2];
                    if (d_we) begin
                        mem_be    = store_be;
                        mem_wdata = store_wdata;
                    end
                end
            end
        end
    end

    // Load data: pick the addressed byte/half, then sign- or zero-extend
    always_comb begin
        case (ctx_q.off)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = ctx_q.off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ctx_q.size)
            2'b00:   ld_ext = {{24{!ctx_q.uns && ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{!ctx_q.uns && ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Response decode from the registered owner
    always_comb begin
        if_rvalid  = (owner_q == OWN_IF);
        if_rdata   = (owner_q == OWN_IF) ? mem_rdata : 32'h0;
        d_rvalid   = (owner_q == OWN_D) && !ctx_q.mis;
        d_misalign = (owner_q == OWN_D) && ctx_q.mis;
        d_rdata    = ((owner_q == OWN_D) && !ctx_q.mis && !ctx_q.we) ? ld_ext : 32'h0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory behind it.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_misalign;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem [0:4095];
    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_WIDTH(12), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_misalign(d_misalign),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory; read data holds when not enabled
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One data access: checks the grant-cycle memory drive and the next-cycle response
    task automatic d_xfer(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [3:0] exp_be, input logic [11:0] exp_maddr,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_unsigned = uns; d_wdata = wdata;
        #1;
        chk({tag, ".d_gnt"}, d_gnt, 1'b1);
        chk({tag, ".mem_en"}, mem_en, 1'b1);
        chk({tag, ".mem_we"}, mem_we, we);
        chk({tag, ".mem_be"}, mem_be, exp_be);
        chk({tag, ".mem_addr"}, mem_addr, exp_maddr);
        if (we) chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
        @(posedge clk); #1;
        d_req = 1'b0;
        chk({tag, ".d_rvalid"}, d_rvalid, 1'b1);
        chk({tag, ".d_misalign"}, d_misalign, 1'b0);
        chk({tag, ".d_rdata"}, d_rdata, exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_if;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0] = 32'h80F0017F;
        mem[4] = 32'hDEADBEEF;
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_size = 2'b00; d_unsigned = 1'b0; d_wdata = 32'h0;

        #12;
        chk("rst.if_rvalid", if_rvalid, 1'b0);
        chk("rst.d_rvalid", d_rvalid, 1'b0);
        chk("rst.d_misalign", d_misalign, 1'b0);
        chk("rst.mem_en", mem_en, 1'b0);
        chk("rst.mem_be", mem_be, 4'b0000);
        chk("rst.d_rdata", d_rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Fetch only
        @(negedge clk); if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("fetch.if_gnt", if_gnt, 1'b1);
        chk("fetch.d_gnt", d_gnt, 1'b0);
        chk("fetch.mem_addr", mem_addr, 12'd4);
        chk("fetch.mem_we", mem_we, 1'b0);
        @(posedge clk); #1;
        chk("fetch.if_rvalid", if_rvalid, 1'b1);
        chk("fetch.if_rdata", if_rdata, 32'hDEADBEEF);
        @(negedge clk); if_req = 1'b0;
        @(posedge clk); #1;
        chk("idle.if_rvalid", if_rvalid, 1'b0);
        chk("idle.if_rdata", if_rdata, 32'h0);

        // Loads with extension
        d_xfer("lb3",  1'b0, 32'h3, 2'b00, 1'b0, 32'h0, 4'b0000, 12'd0, 32'h0, 32'hFFFFFF80);
        d_xfer("lbu3", 1'b0, 32'h3, 2'b00, 1'b1, 32'h0, 4'b0000, 12'd0, 32'h0, 32'h00000080);
        d_xfer("lh2",  1'b0, 32'h2, 2'b01, 1'b0, 32'h0, 4'b0000, 12'd0, 32'h0, 32'hFFFF80F0);
        d_xfer("lhu2", 1'b0, 32'h2, 2'b01, 1'b1, 32'h0, 4'b0000, 12'd0, 32'h0, 32'h000080F0);
        d_xfer("lh0",  1'b0, 32'h0, 2'b01, 1'b0, 32'h0, 4'b0000, 12'd0, 32'h0, 32'h0000017F);
        d_xfer("lw0",  1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 4'b0000, 12'd0, 32'h0, 32'h80F0017F);

        // Stores with lane steering, then read back (including an aliased address)
        d_xfer("sb21", 1'b1, 32'h21, 2'b00, 1'b0, 32'h12345678, 4'b0010, 12'd8, 32'h78787878, 32'h0);
        d_xfer("sh22", 1'b1, 32'h22, 2'b01, 1'b0, 32'h12345678, 4'b1100, 12'd8, 32'h56785678, 32'h0);
        d_xfer("lw20", 1'b0, 32'h4020, 2'b11, 1'b0, 32'h0, 4'b0000, 12'd8, 32'h0, 32'h56787800);
        d_xfer("sw30", 1'b1, 32'h30, 2'b10, 1'b0, 32'hCAFEF00D, 4'b1111, 12'd12, 32'hCAFEF00D, 32'h0);
        d_xfer("lb31", 1'b0, 32'h31, 2'b00, 1'b0, 32'h0, 4'b0000, 12'd12, 32'h0, 32'hFFFFFFF0);

        // Both requesting continuously: fetch forced through every fifth cycle
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_size = 2'b10; d_unsigned = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            exp_if = ((i % 5) == 4);
            #1;
            chk($sformatf("starve%0d.if_gnt", i), if_gnt, exp_if);
            chk($sformatf("starve%0d.d_gnt", i), d_gnt, !exp_if);
            @(posedge clk); #1;
            chk($sformatf("starve%0d.if_rvalid", i), if_rvalid, exp_if);
            chk($sformatf("starve%0d.d_rvalid", i), d_rvalid, !exp_if);
        end
        @(negedge clk); if_req = 1'b0; d_req = 1'b0;
        @(posedge clk);

        // Misaligned word with fetch pending
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6; d_size = 2'b10;
        #1;
        chk("mis.d_gnt", d_gnt, 1'b1);
        chk("mis.if_gnt", if_gnt, 1'b0);
        chk("mis.mem_en", mem_en, 1'b0);
        @(posedge clk); #1;
        d_req = 1'b0;
        #1;
        chk("mis.d_misalign", d_misalign, 1'b1);
        chk("mis.d_rvalid", d_rvalid, 1'b0);
        chk("mis.d_rdata", d_rdata, 32'h0);
        chk("mis.if_gnt_next", if_gnt, 1'b1);
        chk("mis.mem_en_next", mem_en, 1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;
        chk("mis.if_rvalid", if_rvalid, 1'b1);
        chk("mis.if_rdata", if_rdata, 32'hDEADBEEF);
        chk("mis.d_misalign_clr", d_misalign, 1'b0);

        // Misaligned half store writes nothing
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h23; d_size = 2'b01; d_wdata = 32'hFFFFFFFF;
        #1;
        chk("mish.mem_en", mem_en, 1'b0);
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("mish.d_misalign", d_misalign, 1'b1);
        d_xfer("mish.rb", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 4'b0000, 12'd8, 32'h0, 32'h56787800);

        // Reset asserted in the response cycle of a load
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_size = 2'b10;
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("rstrsp.d_rvalid_pre", d_rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstrsp.d_rvalid", d_rvalid, 1'b0);
        chk("rstrsp.d_rdata", d_rdata, 32'h0);
        chk("rstrsp.mem_en", mem_en, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstrsp.d_rvalid_post", d_rvalid, 1'b0);
        chk("rstrsp.if_rvalid_post", if_rvalid, 1'b0);
        chk("rstrsp.d_misalign_post", d_misalign, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the core's single-ported, word-organised instruction/data memory. It shares one synchronous memory between the instruction-fetch port and the load/store port. It also performs byte-lane steering for sub-word stores, sign/zero extension for lb/lh/lbu/lhu, and misalignment rejection. It sits between the pipeline's IF/MEM stages and the memory macro.

## Interface
Parameters:
- ADDR_WIDTH, 12, word-address bits; memory holds 2**ADDR_WIDTH 32-bit words
- STARVE_LIMIT, 4, consecutive cycles fetch may lose arbitration before it is forced to win

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetched word
- d_req  in  1  load/store request
- d_we  in  1  1 = store
- d_addr  in  32  data byte address
- d_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- d_unsigned  in  1  zero-extend loads
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data response (load data or store ack)
- d_rdata  out  32  extended load data; 0 for stores
- d_misalign  out  1  misaligned access response, in place of d_rvalid
- mem_en, mem_we  out  1  memory enable / write enable
- mem_be  out  4  byte write enables
- mem_addr  out  ADDR_WIDTH  word address = addr[ADDR_WIDTH+1:2]; upper bits ignored (aliasing)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data, valid one cycle after mem_en

## Operation
- Arbitration runs every cycle; the winner's access is driven to the memory combinationally that cycle. At most one grant per cycle.
- Priority: data wins over fetch, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt: increments when if_req=1 and if_gnt=0; clears on if_gnt or when if_req=0; saturates at STARVE_LIMIT.
- Fetch address: if_addr[1:0] ignored; always a full word read. mem_we=0.
- Data alignment: half requires addr[0]=0; word requires addr[1:0]=0.
- Misaligned data request: granted, but no memory access (mem_en=0). The next cycle drives d_misalign=1 and d_rvalid=0. If fetch is also requesting in that cycle, fetch takes the memory that same cycle.
- Store lanes, with off=addr[1:0]:
  - byte: mem_be=1<<off, mem_wdata={4{d_wdata[7:0]}}
  - half: mem_be=0011 (off=0) or 1100 (off=2), mem_wdata={2{d_wdata[15:0]}}
  - word: mem_be=1111, mem_wdata=d_wdata
- Loads: mem_be=0000. Response byte/half is selected by the registered off and extended per the registered d_size and d_unsigned.
- Response tracking: a registered owner (NONE/IF/D) plus off, size, unsigned and we, captured at grant. Response outputs are decoded from these registers and mem_rdata.
- Internal state: owner register and starve_cnt only. No other FSM states; back-to-back grants are allowed every cycle (fully pipelined).

## Timing
- Request in cycle N: gnt in cycle N; rvalid or misalign in cycle N+1, one-cycle pulse.
- Requesters hold req/addr/data until gnt. An ungranted request is not latched.
- Reset, asynchronous:
  - owner=NONE, starve_cnt=0
  - if_rvalid, d_rvalid, d_misalign = 0; if_rdata, d_rdata = 0
  - mem_en, mem_we = 0; mem_be = 0
  - A response in flight at reset is dropped and never delivered.
- Outputs with no owner: rvalid=0, rdata=0.
- Simultaneous if_req and d_req with starve_cnt<STARVE_LIMIT: d_gnt=1, if_gnt=0.

## Test plan
- Fetch only, if_addr=0x10 with mem[4]=0xDEADBEEF: if_gnt same cycle, mem_addr=4; next cycle if_rvalid=1, if_rdata=0xDEADBEEF.
- Loads from word 0x80F0017F:
  - lb at addr 3 -> d_rdata=0xFFFFFF80
  - lbu at addr 3 -> 0x00000080
  - lh at addr 2 -> 0xFFFF80F0
  - lw at addr 0 -> 0x80F0017F
- Stores:
  - sb d_wdata=0x12345678 at addr 0x21 -> mem_be=0010, mem_wdata=0x78787878, mem_addr=8
  - sh at addr 0x22 -> mem_be=1100
  - next-cycle d_rvalid=1, d_rdata=0
- Both ports requesting continuously, STARVE_LIMIT=4: pattern is d,d,d,d,if,d,d,d,d,if…; fetch is never starved more than 4 cycles.
- Misaligned lw at addr 0x6, with fetch also requesting: d_gnt=1, mem_en=0 that cycle; next cycle d_misalign=1, d_rvalid=0, and fetch is granted.
- rst_n asserted during the response cycle of a load: d_rvalid=0 immediately and stays 0 after release; all outputs hold reset values.
